// File: rtl/rvv_pkg.sv
// Shared constants and types for the vector ALU sequencer slice: funct6 codes,
// operand-type codes, element-width codes and the sequencer state encoding.
package rvv_pkg;

  localparam logic [5:0] F6_VADD  = 6'b000000;
  localparam logic [5:0] F6_VSUB  = 6'b000010;
  localparam logic [5:0] F6_VAND  = 6'b001001;
  localparam logic [5:0] F6_VOR   = 6'b001010;
  localparam logic [5:0] F6_VXOR  = 6'b001011;
  localparam logic [5:0] F6_VMAND = 6'b011001;
  localparam logic [5:0] F6_VMOR  = 6'b011010;
  localparam logic [5:0] F6_VMXOR = 6'b011011;

  localparam logic [2:0] OP_VV = 3'b001;
  localparam logic [2:0] OP_VX = 3'b010;
  localparam logic [2:0] OP_VI = 3'b100;

  localparam logic [2:0] SEW_8  = 3'd0;
  localparam logic [2:0] SEW_16 = 3'd1;
  localparam logic [2:0] SEW_32 = 3'd2;
  localparam logic [2:0] SEW_64 = 3'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/rvv_wb_merge.sv
// Writeback merge: overlays each valid lane's chunk onto a base vector at the
// lane's bit index, limited to the chunk width and to bits below bit_lim_i.
module rvv_wb_merge
  import rvv_pkg::*;
#(
  parameter int VLEN  = 128,
  parameter int LANES = 1
) (
  input  logic [VLEN-1:0]     base_i,
  input  logic [64*LANES-1:0] lane_vd_i,
  input  logic [10*LANES-1:0] lane_idx_i,
  input  logic [LANES-1:0]    lane_vld_i,
  input  logic [2:0]          w_log_i,
  input  logic [10:0]         bit_lim_i,
  output logic [VLEN-1:0]     merged_o
);

  logic [10:0] idx;
  logic [10:0] rel;
  logic [6:0]  w;
  logic [63:0] chunk;

  always_comb begin
    merged_o = base_i;
    idx      = '0;
    rel      = '0;
    chunk    = '0;
    w        = 7'd1 << w_log_i;
    for (int b = 0; b < VLEN; b++) begin
      for (int k = 0; k < LANES; k++) begin
        idx   = {1'b0, lane_idx_i[10*k +: 10]};
        chunk = lane_vd_i[64*k +: 64];
        rel   = 11'(b) - idx;
        if (lane_vld_i[k] && (idx <= 11'(b)) && (rel < {4'b0, w}) && (11'(b) < bit_lim_i))
          merged_o[b] = chunk[rel[5:0]];
      end
    end
  end

endmodule

// File: rtl/rvv_alu_seq.sv
// Vector ALU sequencer: steps element groups and in-element chunks through the
// lanes every cycle and assembles their chunk results into a VLEN-wide vd.
module rvv_alu_seq
  import rvv_pkg::*;
#(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 3,
  parameter int LANES      = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [5:0]          opcode,
  input  logic                instr_mask,
  input  logic [2:0]          op_type,
  input  logic [2:0]          vsew,
  input  logic [9:0]          vl,
  input  logic [VLEN-1:0]     vd_old,
  output logic                alu_run,
  output logic [9:0]          alu_byte_i,
  output logic [3:0]          alu_in_reg_offset,
  input  logic [64*LANES-1:0] alu_vd,
  input  logic [10*LANES-1:0] alu_index,
  input  logic                alu_instr_valid,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic [VLEN-1:0]     vd_out
);

  seq_state_e      state_q;
  logic            run_q, busy_q, done_q, illegal_q, mask_q;
  logic [9:0]      byte_q;
  logic [3:0]      off_q, last_off_q;
  logic [10:0]     groups_q, eff_vl_q;
  logic [2:0]      w_log_q;
  logic [VLEN-1:0] vd_q, merged;
  logic [LANES-1:0] lane_vld;
  logic [10:0]     bit_lim;

  logic [2:0]  ew_log_s, w_log_s;
  logic [10:0] cap_s, eff_vl_s, groups_s;
  logic [3:0]  last_off_s;
  logic        illegal_s;

  // opcode and op_type are decoded by the lanes themselves.
  logic unused_instr;
  assign unused_instr = ^{opcode, op_type};

  always_comb begin
    ew_log_s   = instr_mask ? 3'(LANE_WIDTH) : ({1'b0, vsew[1:0]} + 3'd3);
    cap_s      = instr_mask ? 11'(VLEN) : 11'(VLEN >> ew_log_s);
    eff_vl_s   = ({1'b0, vl} < cap_s) ? {1'b0, vl} : cap_s;
    groups_s   = instr_mask ? 11'((eff_vl_s + 11'((1 << LANE_WIDTH) - 1)) >> LANE_WIDTH)
                            : eff_vl_s;
    last_off_s = (ew_log_s > 3'(LANE_WIDTH))
                 ? 4'((1 << (ew_log_s - 3'(LANE_WIDTH))) - 1) : 4'd0;
    w_log_s    = (ew_log_s < 3'(LANE_WIDTH)) ? ew_log_s : 3'(LANE_WIDTH);
    illegal_s  = !alu_instr_valid || (vsew > 3'd3);
  end

  // Lane k holds element group byte_q+k; mask ops are further clipped per bit.
  always_comb begin
    lane_vld = '0;
    for (int k = 0; k < LANES; k++)
      lane_vld[k] = ({1'b0, byte_q} + 11'(k)) < groups_q;
    bit_lim = mask_q ? eff_vl_q : 11'(VLEN);
  end

  rvv_wb_merge #(
    .VLEN  (VLEN),
    .LANES (LANES)
  ) u_merge (
    .base_i     (vd_q),
    .lane_vd_i  (alu_vd),
    .lane_idx_i (alu_index),
    .lane_vld_i (lane_vld),
    .w_log_i    (w_log_q),
    .bit_lim_i  (bit_lim),
    .merged_o   (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      run_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      byte_q    <= '0;
      off_q     <= '0;
      vd_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            vd_q       <= vd_old;
            mask_q     <= instr_mask;
            eff_vl_q   <= eff_vl_s;
            groups_q   <= groups_s;
            last_off_q <= last_off_s;
            w_log_q    <= w_log_s;
            illegal_q  <= illegal_s;
            byte_q     <= '0;
            off_q      <= '0;
            if (illegal_s || (eff_vl_s == 11'd0)) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              run_q   <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          vd_q <= merged;
          if (off_q == last_off_q) begin
            off_q <= '0;
            if (({1'b0, byte_q} + 11'(LANES)) >= groups_q) begin
              state_q <= FIN;
              run_q   <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              byte_q  <= '0;
            end else begin
              byte_q <= byte_q + 10'(LANES);
            end
          end else begin
            off_q <= off_q + 4'd1;
          end
        end
        FIN: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_run           = run_q;
  assign alu_byte_i        = byte_q;
  assign alu_in_reg_offset = off_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign illegal           = illegal_q;
  assign vd_out            = vd_q;

endmodule
